dcsk_demod_ctrl: RTL and testbench

Parametrised successor to the receive-side DCSK demodulation controller.
- Sequences the variable-delay reference store: write reference chips, then read them back against the information chips.
- Counts per-chip correlation results internally and makes a majority decision per symbol.
- Assembles FRAME_BITS decided bits into a word and hands it downstream with a valid/ready handshake.
- Runs symbols back-to-back with no dead cycle and re-samples the spread factor at every symbol boundary.

---
 rtl/dcsk_rx_pkg.sv | 21 ++
 rtl/dcsk_frame_out_reg.sv | 63 ++++++
 rtl/dcsk_demod_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dcsk_demod_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcsk_rx_pkg.sv
// -----------------------------------------------------------------------------
// dcsk_rx_pkg
// Shared types and default sizing for the DCSK receive-side demodulation path.
//   demod_state_t      : demodulator controller states
//   SF_W_DEFAULT       : width of the spread-factor / chip-index datapath
//   FRAME_BITS_DEFAULT : decided bits per output word
//   MIN_SF_DEFAULT     : smallest spread factor the controller will run with
// -----------------------------------------------------------------------------
package dcsk_rx_pkg;

  typedef enum logic [1:0] {
    DEMOD_IDLE      = 2'd0,
    DEMOD_STORE_REF = 2'd1,
    DEMOD_CORRELATE = 2'd2
  } demod_state_t;

  localparam int SF_W_DEFAULT       = 5;
  localparam int FRAME_BITS_DEFAULT = 32;
  localparam int MIN_SF_DEFAULT     = 2;

endpackage

// File: rtl/dcsk_frame_out_reg.sv
// -----------------------------------------------------------------------------
// dcsk_frame_out_reg
// Output holding register for demodulated words with a valid/ready handshake.
// Ports:
//   clk_i, rst_i   : clock (rising edge), asynchronous active-high reset
//   load_i         : a completed word is presented on data_i this cycle
//   data_i         : completed word
//   ready_i        : downstream accepts data_o while valid_o=1
//   data_o         : held word
//   valid_o        : data_o holds a word not yet accepted
//   overrun_o      : one-cycle pulse when an unaccepted word is overwritten
// -----------------------------------------------------------------------------
module dcsk_frame_out_reg
  import dcsk_rx_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [FRAME_BITS-1:0] data_i,
  input  logic                  ready_i,
  output logic [FRAME_BITS-1:0] data_o,
  output logic                  valid_o,
  output logic                  overrun_o
);

  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      data_d    = data_i;
      valid_d   = 1'b1;
      // Only a word that is still pending and not taken this very cycle is lost.
      overrun_d = valid_q & ~ready_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/dcsk_demod_ctrl.sv
// -----------------------------------------------------------------------------
// dcsk_demod_ctrl
// Receive-side DCSK demodulation controller. Sequences the reference delay
// store (write reference chips, read them back against information chips),
// counts per-chip correlation hits, takes a majority decision per symbol and
// assembles FRAME_BITS decisions into a word handed downstream.
// Configuration macro: DCSK_DEMOD_STALL_EN
//   undefined : In_Valid=0 mid-symbol aborts to IDLE (Sym_Abort may pulse)
//   defined   : In_Valid=0 mid-symbol freezes the controller; Sym_Abort is 0
// Ports:
//   Clk, Rst       : clock (rising edge), asynchronous active-high reset
//   In_Valid       : chip qualifier
//   Chip_Corr      : XNOR of reference and information chip (CORRELATE)
//   Spread_Factor  : chips per half-symbol, sampled at symbol start
//   Del_Addr       : delay-store address (current chip index)
//   Del_Load       : delay-store write strobe
//   Del_Re         : delay-store read strobe
//   Out_Data       : demodulated word, bit 0 = first symbol of the frame
//   Out_Valid      : Out_Data holds an unaccepted word
//   Out_Ready      : downstream accept
//   Sym_Abort      : one-cycle pulse when a partial symbol/frame is discarded
//   Frame_Overrun  : one-cycle pulse when an unaccepted word is overwritten
// -----------------------------------------------------------------------------
module dcsk_demod_ctrl
  import dcsk_rx_pkg::*;
#(
  parameter int SF_W       = SF_W_DEFAULT,
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int MIN_SF     = MIN_SF_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  In_Valid,
  input  logic                  Chip_Corr,
  input  logic [SF_W-1:0]       Spread_Factor,
  output logic [SF_W-1:0]       Del_Addr,
  output logic                  Del_Load,
  output logic                  Del_Re,
  output logic [FRAME_BITS-1:0] Out_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic                  Sym_Abort,
  output logic                  Frame_Overrun
);

  localparam int              BC_W     = $clog2(FRAME_BITS);
  localparam logic [SF_W-1:0] MIN_SF_V = SF_W'(MIN_SF);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_BITS - 1);

  demod_state_t          state_q, state_d;
  logic [SF_W-1:0]       sf_q, sf_d;
  logic [SF_W-1:0]       chip_q, chip_d;
  logic [SF_W-1:0]       ones_q, ones_d;
  logic [BC_W-1:0]       bit_q, bit_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;

  logic                  word_load;
  logic [FRAME_BITS-1:0] word_data;

  logic [SF_W-1:0]       sf_clamped;
  logic                  last_chip;
  logic [SF_W-1:0]       ones_inc;
  logic                  decision_bit;

`ifndef DCSK_DEMOD_STALL_EN
  logic                  abort_q, abort_d;
`endif

  assign sf_clamped = (Spread_Factor < MIN_SF_V) ? MIN_SF_V : Spread_Factor;
  assign last_chip  = (chip_q == (sf_q - SF_W'(1)));
  // ones_q never exceeds sf_q-1 before the add, so the sum fits in SF_W bits.
  assign ones_inc   = ones_q + SF_W'(Chip_Corr);
  // Strict majority: 2*ones > sf. A tie decides 0.
  assign decision_bit = ({ones_inc, 1'b0} > {1'b0, sf_q});

  always_comb begin
    state_d   = state_q;
    sf_d      = sf_q;
    chip_d    = chip_q;
    ones_d    = ones_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    word_load = 1'b0;
    word_data = '0;
`ifndef DCSK_DEMOD_STALL_EN
    abort_d   = 1'b0;
`endif

    case (state_q)
      DEMOD_IDLE: begin
        if (In_Valid) begin
          // This cycle already carries reference chip 0.
          sf_d    = sf_clamped;
          chip_d  = SF_W'(1);
          state_d = DEMOD_STORE_REF;
        end
      end

      DEMOD_STORE_REF, DEMOD_CORRELATE: begin
        if (In_Valid) begin
          if (state_q == DEMOD_STORE_REF) begin
            if (last_chip) begin
              chip_d  = '0;
              state_d = DEMOD_CORRELATE;
            end else begin
              chip_d = chip_q + SF_W'(1);
            end
          end else if (last_chip) begin
            frame_d[bit_q] = decision_bit;
            ones_d  = '0;
            chip_d  = '0;
            sf_d    = sf_clamped;
            state_d = DEMOD_STORE_REF;
            if (bit_q == LAST_BIT) begin
              word_load = 1'b1;
              word_data = frame_d;
              frame_d   = '0;
              bit_d     = '0;
            end else begin
              bit_d = bit_q + BC_W'(1);
            end
          end else begin
            ones_d = ones_inc;
            chip_d = chip_q + SF_W'(1);
          end
        end else begin
`ifndef DCSK_DEMOD_STALL_EN
          // End of burst: drop any partial symbol/frame. Ending exactly on a
          // frame boundary is a clean stop and does not flag an abort.
          abort_d = (chip_q != '0) || (bit_q != '0);
          state_d = DEMOD_IDLE;
          chip_d  = '0;
          ones_d  = '0;
          bit_d   = '0;
          frame_d = '0;
`endif
        end
      end

      default: begin
        state_d = DEMOD_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= DEMOD_IDLE;
      sf_q    <= '0;
      chip_q  <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      sf_q    <= sf_d;
      chip_q  <= chip_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
    end
  end

`ifndef DCSK_DEMOD_STALL_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end
  assign Sym_Abort = abort_q;
`else
  assign Sym_Abort = 1'b0;
`endif

  // Strobes are masked while Rst is held so the store sees no access during reset.
  assign Del_Addr = chip_q;
  assign Del_Load = ~Rst & In_Valid &
                    ((state_q == DEMOD_IDLE) || (state_q == DEMOD_STORE_REF));
  assign Del_Re   = ~Rst & In_Valid & (state_q == DEMOD_CORRELATE);

  dcsk_frame_out_reg #(
    .FRAME_BITS (FRAME_BITS)
  ) u_frame_out (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .load_i    (word_load),
    .data_i    (word_data),
    .ready_i   (Out_Ready),
    .data_o    (Out_Data),
    .valid_o   (Out_Valid),
    .overrun_o (Frame_Overrun)
  );

endmodule

// File: tb/tb_dcsk_demod_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcsk_demod_ctrl
// Directed bench for dcsk_demod_ctrl (SF_W=5, FRAME_BITS=8, MIN_SF=2).
// Spread_Factor is driven with the value intended for the following symbol
// for the whole of the current symbol (except chip 0 of a burst), so every
// symbol also shows that mid-symbol changes are ignored.
// -----------------------------------------------------------------------------
module tb_dcsk_demod_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       In_Valid = 1'b0;
  logic       Chip_Corr = 1'b0;
  logic [4:0] Spread_Factor = 5'd4;
  logic [4:0] Del_Addr;
  logic       Del_Load;
  logic       Del_Re;
  logic [7:0] Out_Data;
  logic       Out_Valid;
  logic       Out_Ready = 1'b0;
  logic       Sym_Abort;
  logic       Frame_Overrun;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int chip_no = 0;
  int ov_rise = 0;
  logic ov_prev = 1'b0;
  int abort_cnt = 0;
  int ovr_cnt = 0;
  int base_a;
  int base_o;

  int ones_t1[8] = '{4, 0, 3, 3, 1, 2, 4, 0};
  int ones_t3[8] = '{0, 8, 4, 5, 3, 6, 1, 7};
  int ones_fa[8] = '{4, 4, 4, 4, 0, 0, 0, 0};
  int ones_fb[8] = '{3, 0, 4, 0, 0, 4, 0, 3};
  int ones_fc[8] = '{4, 4, 0, 0, 4, 4, 0, 0};
  int ones_fd[8] = '{1, 1, 1, 1, 3, 3, 3, 3};

  always #5 Clk = ~Clk;

  dcsk_demod_ctrl #(
    .SF_W       (5),
    .FRAME_BITS (8),
    .MIN_SF     (2)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .In_Valid      (In_Valid),
    .Chip_Corr     (Chip_Corr),
    .Spread_Factor (Spread_Factor),
    .Del_Addr      (Del_Addr),
    .Del_Load      (Del_Load),
    .Del_Re        (Del_Re),
    .Out_Data      (Out_Data),
    .Out_Valid     (Out_Valid),
    .Out_Ready     (Out_Ready),
    .Sym_Abort     (Sym_Abort),
    .Frame_Overrun (Frame_Overrun)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Sym_Abort === 1'b1) abort_cnt++;
    if (Frame_Overrun === 1'b1) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, optionally check the combinational strobes, clock.
  task automatic chip(input logic v, input logic c, input logic [4:0] sfv,
                      input logic ld_e, input logic re_e, input logic [4:0] ad_e,
                      input bit chk);
    In_Valid      = v;
    Chip_Corr     = c;
    Spread_Factor = sfv;
    chip_no++;
    #1;
    if (chk) begin
      check("del_addr", 32'(Del_Addr), 32'(ad_e));
      check("del_load", 32'(Del_Load), 32'(ld_e));
      check("del_re",   32'(Del_Re),   32'(re_e));
    end
    @(posedge Clk);
    #1;
    if (Out_Valid && !ov_prev) ov_rise = chip_no + 1;
    ov_prev = Out_Valid;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) chip(1'b0, 1'b0, Spread_Factor, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // One full symbol at spread factor s with 'ones' correlation hits.
  task automatic sym(input int s, input int nxt, input int ones, input bit first,
                     input bit rdy_last);
    int e;
    e = (s < 2) ? 2 : s;
    for (int i = 0; i < e; i++)
      chip(1'b1, 1'b0, (i == 0 && first) ? 5'(s) : 5'(nxt), 1'b1, 1'b0, 5'(i), 1'b1);
    for (int i = 0; i < e; i++) begin
      if (i == e - 1 && rdy_last) Out_Ready = 1'b1;
      chip(1'b1, (i < ones), 5'(nxt), 1'b0, 1'b1, 5'(i), 1'b1);
      if (i == e - 1 && rdy_last) Out_Ready = 1'b0;
    end
  endtask

  initial begin
    // ---------------- Reset state ----------------
    @(posedge Clk);
    #1;
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_out_data",  32'(Out_Data),  32'd0);
    check("rst_sym_abort", 32'(Sym_Abort), 32'd0);
    check("rst_overrun",   32'(Frame_Overrun), 32'd0);
    check("rst_del_addr",  32'(Del_Addr),  32'd0);
    check("rst_del_load",  32'(Del_Load),  32'd0);
    Rst = 1'b0;
    idle(2);

    // ---------------- SF=4 frame, latency, address trace, tie ----------------
    chip_no = 0;
    ov_rise = 0;
    base_a  = abort_cnt;
    for (int k = 0; k < 8; k++) sym(4, 4, ones_t1[k], (k == 0), 1'b0);
    check("t1_out_valid", 32'(Out_Valid), 32'd1);
    check("t1_out_data",  32'(Out_Data),  32'h4D);
    check("t1_latency",   32'(ov_rise),   32'd65);
    idle(2);
    check("t1_clean_end_no_abort", 32'(abort_cnt - base_a), 32'd0);
    check("t1_hold_unaccepted", 32'(Out_Valid), 32'd1);
    Out_Ready = 1'b1;
    idle(1);
    Out_Ready = 1'b0;
    check("t1_accept_clears", 32'(Out_Valid), 32'd0);

    // ---------------- SF=8 abort mid-CORRELATE ----------------
    base_a = abort_cnt;
    sym(8, 8, 8, 1'b1, 1'b0);
    sym(8, 8, 0, 1'b0, 1'b0);
    sym(8, 8, 5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) chip(1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 5'(i), 1'b1);
    for (int i = 0; i < 2; i++) chip(1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 5'(i), 1'b1);
    chip(1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 5'd2, 1'b1);
    idle(2);
    check("t3_abort_pulses", 32'(abort_cnt - base_a), 32'd1);
    check("t3_no_word", 32'(Out_Valid), 32'd0);
    for (int k = 0; k < 7; k++) sym(8, 8, ones_t3[k], (k == 0), 1'b0);
    check("t3_no_early_word", 32'(Out_Valid), 32'd0);
    sym(8, 8, ones_t3[7], 1'b0, 1'b0);
    check("t3_out_valid", 32'(Out_Valid), 32'd1);
    check("t3_out_data",  32'(Out_Data),  32'hAA);
    idle(2);
    check("t3_single_abort", 32'(abort_cnt - base_a), 32'd1);
    Out_Ready = 1'b1;
    idle(1);
    Out_Ready = 1'b0;

    // ---------------- Overrun, then simultaneous accept ----------------
    base_o = ovr_cnt;
    for (int k = 0; k < 8; k++) sym(4, 4, ones_fa[k], (k == 0), 1'b0);
    check("t4_word_a", 32'(Out_Data), 32'h0F);
    for (int k = 0; k < 8; k++) sym(4, 4, ones_fb[k], 1'b0, 1'b0);
    idle(1);
    check("t4_overrun_pulse", 32'(ovr_cnt - base_o), 32'd1);
    check("t4_word_b", 32'(Out_Data), 32'hA5);
    check("t4_valid_b", 32'(Out_Valid), 32'd1);
    for (int k = 0; k < 8; k++) sym(4, 4, ones_fc[k], (k == 0), (k == 7));
    idle(1);
    check("t4_no_overrun_on_accept", 32'(ovr_cnt - base_o), 32'd1);
    check("t4_valid_c", 32'(Out_Valid), 32'd1);
    check("t4_word_c", 32'(Out_Data), 32'h33);
    Out_Ready = 1'b1;
    idle(1);
    Out_Ready = 1'b0;
    check("t4_cleared", 32'(Out_Valid), 32'd0);

    // ---------------- Spread factor switching and clamping ----------------
    sym(3, 5, 2, 1'b1, 1'b0);
    sym(5, 0, 2, 1'b0, 1'b0);
    sym(0, 1, 1, 1'b0, 1'b0);
    sym(1, 2, 2, 1'b0, 1'b0);
    sym(2, 2, 2, 1'b0, 1'b0);
    sym(2, 2, 0, 1'b0, 1'b0);
    sym(2, 2, 1, 1'b0, 1'b0);
    sym(2, 2, 2, 1'b0, 1'b0);
    check("t5_valid", 32'(Out_Valid), 32'd1);
    check("t5_word", 32'(Out_Data), 32'h99);
    idle(1);

    // ---------------- Async reset mid-CORRELATE with a pending word ----------------
    for (int i = 0; i < 4; i++) chip(1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 5'(i), 1'b1);
    for (int i = 0; i < 2; i++) chip(1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 5'(i), 1'b1);
    Rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(Out_Valid), 32'd0);
    check("t6_rst_data", 32'(Out_Data), 32'd0);
    check("t6_rst_addr", 32'(Del_Addr), 32'd0);
    check("t6_rst_load", 32'(Del_Load), 32'd0);
    check("t6_rst_re", 32'(Del_Re), 32'd0);
    check("t6_rst_abort", 32'(Sym_Abort), 32'd0);
    check("t6_rst_overrun", 32'(Frame_Overrun), 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    check("t6_post_rst_valid", 32'(Out_Valid), 32'd0);
    for (int k = 0; k < 8; k++) sym(4, 4, ones_fd[k], (k == 0), 1'b0);
    check("t6_word_after_rst", 32'(Out_Data), 32'hF0);
    check("t6_valid_after_rst", 32'(Out_Valid), 32'd1);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
